// File: rtl/btn_evt_pkg.sv
// Shared event codes and per-button FSM state encoding for button_event_ctrl.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] LONG    = 2'd2;

  // Counter width able to hold the larger of the two thresholds.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/btn_fsm.sv
// Per-button edge detect, PRESS/RELEASE/LONG(/REPEAT) FSM, hold counter and
// one-deep pending event slot. Auto-repeat in LONG exists only when
// BUTTON_AUTOREPEAT_EN is defined.
module btn_fsm
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50000000,
`ifdef BUTTON_AUTOREPEAT_EN
  parameter int unsigned REPEAT_CYCLES = 10000000,
`endif
  parameter int unsigned CNT_W         = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clean,
  input  logic       drain,
  output logic       slot_valid,
  output logic [1:0] slot_code,
  output logic       held,
  output logic       drop_c
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             clean_q;
  logic             clean_prev;
  logic             rise;
  logic             fall;
  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             post;
  logic [1:0]       post_code;

  // Capture stage then edge detect; reset loads the live level so a button
  // held through reset is treated as already seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      clean_q    <= clean;
      clean_prev <= clean;
    end else begin
      clean_q    <= clean;
      clean_prev <= clean_q;
    end
  end

  assign rise = clean_q & ~clean_prev;
  assign fall = ~clean_q & clean_prev;

  // FSM state and hold counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      held  <= (state_d != IDLE);
    end
  end

  // Next state, counter and event posting; fall beats the threshold.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    post      = 1'b0;
    post_code = EVT_PRESS;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          post      = 1'b1;
          post_code = EVT_PRESS;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d   = IDLE;
          post      = 1'b1;
          post_code = EVT_RELEASE;
        end else if (cnt == LONG_LAST) begin
          state_d   = LONG;
          cnt_d     = '0;
          post      = 1'b1;
          post_code = EVT_LONG;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (fall) begin
          state_d   = IDLE;
          post      = 1'b1;
          post_code = EVT_RELEASE;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (cnt == REPEAT_LAST) begin
          cnt_d     = '0;
          post      = 1'b1;
          post_code = EVT_REPEAT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // A post into a full slot that is not leaving this cycle is lost.
  assign drop_c = post & slot_valid & ~drain;

  // Pending slot: a same-cycle drain and post keeps the new event.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_code  <= EVT_PRESS;
    end else if (post && !drop_c) begin
      slot_valid <= 1'b1;
      slot_code  <= post_code;
    end else if (drain) begin
      slot_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: per-button FSMs feeding a round-robin scheduler
// onto one valid/ready event stream. Define BUTTON_AUTOREPEAT_EN to enable
// REPEAT events while a button stays in LONG.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter  int unsigned N_BTN         = 4,
  parameter  int unsigned LONG_CYCLES   = 50000000,
  parameter  int unsigned REPEAT_CYCLES = 10000000,
  localparam int unsigned BTN_W         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] clean,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [BTN_W-1:0] evt_btn,
  output logic [1:0]       evt_code,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] overflow,
  input  logic             ovf_clr
);

  localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

  logic [N_BTN-1:0]      slot_valid;
  logic [N_BTN-1:0][1:0] slot_code;
  logic [N_BTN-1:0]      drain;
  logic [N_BTN-1:0]      drop;
  logic [BTN_W-1:0]      rr_ptr;
  logic [BTN_W-1:0]      grant;
  logic                  found;
  logic                  load;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_fsm #(
      .LONG_CYCLES  (LONG_CYCLES),
`ifdef BUTTON_AUTOREPEAT_EN
      .REPEAT_CYCLES(REPEAT_CYCLES),
`endif
      .CNT_W        (CNT_W)
    ) u_fsm (
      .clock     (clock),
      .reset     (reset),
      .clean     (clean[i]),
      .drain     (drain[i]),
      .slot_valid(slot_valid[i]),
      .slot_code (slot_code[i]),
      .held      (held[i]),
      .drop_c    (drop[i])
    );
  end

  assign load = ~evt_valid | evt_ready;

  // First valid slot at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    grant = '0;
    j     = 0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      j = (32'(rr_ptr) + k) % N_BTN;
      if (!found && slot_valid[BTN_W'(j)]) begin
        found = 1'b1;
        grant = BTN_W'(j);
      end
    end
    drain = (load && found) ? (N_BTN'(1) << grant) : '0;
  end

  // Output register and round-robin pointer; holds while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_code  <= EVT_PRESS;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_btn  <= grant;
        evt_code <= slot_code[grant];
        rr_ptr   <= BTN_W'((32'(grant) + 1) % N_BTN);
      end
    end
  end

  // Sticky overflow; a drop coinciding with the clear still sets its bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= '0;
    end else begin
      overflow <= (ovf_clr ? '0 : overflow) | drop;
    end
  end

endmodule
